// File: rtl/watch_pkg.sv
// Shared encodings for the watch control slice: modes, button indices, priority pick
// and the mode LED decode.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_EDIT  = 2'd1,
    MODE_TIMER = 2'd2
  } mode_e;

  localparam int BTN_CLR   = 0;
  localparam int BTN_MODE  = 1;
  localparam int BTN_SHIFT = 2;
  localparam int BTN_INC   = 3;
  localparam int BTN_SS    = 4;
  localparam int NUM_BTN   = 5;

  localparam int HOLD_CYCLES_DFLT = 15_000_000;

  // Priority clr > mode > shift > inc > ss.
  function automatic logic [2:0] btn_pick(input logic [NUM_BTN-1:0] b);
    if (b[BTN_CLR])        return 3'(BTN_CLR);
    else if (b[BTN_MODE])  return 3'(BTN_MODE);
    else if (b[BTN_SHIFT]) return 3'(BTN_SHIFT);
    else if (b[BTN_INC])   return 3'(BTN_INC);
    else                   return 3'(BTN_SS);
  endfunction

  function automatic logic [2:0] mode_led_of(input mode_e m);
    case (m)
      MODE_CLOCK: return 3'b100;
      MODE_EDIT:  return 3'b010;
      MODE_TIMER: return 3'b001;
      default:    return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_btn_sync.sv
// Two-flop synchronizer for the raw front-panel button vector.
module btn_sync
  import watch_pkg::*;
#(
  parameter int W = NUM_BTN
) (
  input  logic         clk,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sync_p0, sync_p1;

  // Stage 0/1: metastability filter
  always_ff @(posedge clk) begin
    sync_p0 <= din;
    sync_p1 <= sync_p0;
  end

  assign dout = sync_p1;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch front-panel control: single-winner button qualification, CLOCK/EDIT/TIMER
// mode FSM, timer run flag and one-cycle command pulses to the datapath.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DFLT,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_clr,
  input  logic       btn_shift,
  input  logic       btn_inc,
  input  logic       btn_ss,
  input  logic       tm_done,
  output logic [1:0] mode,
  output logic [2:0] mode_led,
  output logic       edit_place,
  output logic       tm_run,
  output logic       cmd_clr,
  output logic       cmd_inc_hi,
  output logic       cmd_inc_lo,
  output logic       tm_enter,
  output logic       edit_exit
);

  logic [NUM_BTN-1:0] btn_raw, btn_s;
  logic               any_btn;
  logic               armed;
  logic               win_vld;
  logic [2:0]         win_idx;
  logic [CNT_W-1:0]   hold_cnt;
  logic               win_held;
  logic               accept;
  logic [NUM_BTN-1:0] acc;
  logic               pend_mode;
  mode_e              mode_q;

  assign btn_raw = {btn_ss, btn_inc, btn_shift, btn_mode, btn_clr};

  btn_sync #(.W(NUM_BTN)) u_btn_sync (
    .clk  (clk),
    .din  (btn_raw),
    .dout (btn_s)
  );

  assign any_btn  = |btn_s;
  assign win_held = win_vld && btn_s[win_idx];
  assign accept   = win_held && (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign acc      = accept ? (NUM_BTN'(1) << win_idx) : '0;
  assign mode     = mode_q;

  // Arbiter and hold counter; armed stays low after reset until every button is up,
  // so a press that straddles reset is never accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed    <= 1'b0;
      win_vld  <= 1'b0;
      win_idx  <= '0;
      hold_cnt <= '0;
    end else if (!any_btn) begin
      armed    <= 1'b1;
      win_vld  <= 1'b0;
      hold_cnt <= '0;
    end else if (!win_vld) begin
      if (armed) begin
        armed    <= 1'b0;
        win_vld  <= 1'b1;
        win_idx  <= btn_pick(btn_s);
        hold_cnt <= CNT_W'(1);
      end
    end else if (win_held) begin
      if (hold_cnt != CNT_W'(HOLD_CYCLES))
        hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Mode FSM, timer run flag and command pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_CLOCK;
      mode_led   <= 3'b100;
      edit_place <= 1'b1;
      tm_run     <= 1'b0;
      pend_mode  <= 1'b0;
      cmd_clr    <= 1'b0;
      cmd_inc_hi <= 1'b0;
      cmd_inc_lo <= 1'b0;
      tm_enter   <= 1'b0;
      edit_exit  <= 1'b0;
    end else begin
      cmd_clr    <= 1'b0;
      cmd_inc_hi <= 1'b0;
      cmd_inc_lo <= 1'b0;
      tm_enter   <= 1'b0;
      edit_exit  <= 1'b0;
      mode_led   <= mode_led_of(mode_q);

      if (!any_btn && pend_mode) begin
        pend_mode <= 1'b0;
        case (mode_q)
          MODE_CLOCK: mode_q <= MODE_EDIT;
          MODE_EDIT: begin
            mode_q    <= MODE_TIMER;
            edit_exit <= 1'b1;
            tm_enter  <= 1'b1;
          end
          MODE_TIMER: if (!tm_run) mode_q <= MODE_CLOCK;
          default:    mode_q <= MODE_CLOCK;
        endcase
      end

      if (accept) begin
        if (mode_q == MODE_TIMER && tm_run) begin
          if (acc[BTN_SS]) tm_run <= 1'b0;
        end else begin
          if (acc[BTN_MODE]) pend_mode <= 1'b1;
          if (mode_q != MODE_CLOCK) begin
            if (acc[BTN_CLR])   cmd_clr    <= 1'b1;
            if (acc[BTN_SHIFT]) edit_place <= ~edit_place;
            if (acc[BTN_INC]) begin
              cmd_inc_hi <= edit_place;
              cmd_inc_lo <= ~edit_place;
            end
            if (acc[BTN_SS] && mode_q == MODE_TIMER) tm_run <= 1'b1;
          end
        end
      end

      // A countdown finish overrides a start accepted in the same cycle.
      if (tm_done) tm_run <= 1'b0;
    end
  end

endmodule
